// File: rtl/cache_pkg.sv
// Shared cache fill definitions: fill FSM states, cache geometry and the
// data RAM address packing used by the fill controller.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        TAG,
        DONE
    } fill_state_t;

    localparam int CACHE_LINE_BEATS = 8;
    localparam int CACHE_INDEX_W    = 11;
    localparam int CACHE_TAG_W      = 11;
    localparam int CACHE_WAYS       = 4;
    localparam int CACHE_WAY_W      = $clog2(CACHE_WAYS);
    localparam int CACHE_BEAT_W     = $clog2(CACHE_LINE_BEATS);
    // tag + index + beat + byte-in-halfword
    localparam int CACHE_ADDR_W     = CACHE_TAG_W + CACHE_INDEX_W + CACHE_BEAT_W + 1;

    function automatic logic [15:0] pack_data_addr(
        input logic [CACHE_WAY_W-1:0]   way,
        input logic [CACHE_INDEX_W-1:0] index,
        input logic [CACHE_BEAT_W-1:0]  beat
    );
        return {way, index, beat};
    endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Fill controller bus: fault request from the tag way, burst read from main
// memory, and the data RAM / tag write outputs.
interface cache_fill_ctrl_if;
    import cache_pkg::*;

    logic                   hard_fault;
    logic [30:0]            target_address;
    logic [CACHE_WAY_W-1:0] fill_way_index;
    logic                   tag_write;
    logic                   fill_busy;
    logic                   fill_done;
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [24:0]            mem_req_addr;
    logic                   mem_rd_valid;
    logic [15:0]            mem_rd_data;
    logic                   data_we;
    logic [15:0]            data_addr;
    logic [15:0]            data_wdata;
    logic                   critical_valid;

    modport master (
        input  hard_fault, target_address, mem_req_ready, mem_rd_valid, mem_rd_data,
        output fill_way_index, tag_write, fill_busy, fill_done, mem_req_valid,
               mem_req_addr, data_we, data_addr, data_wdata, critical_valid
    );

    modport slave (
        output hard_fault, target_address, mem_req_ready, mem_rd_valid, mem_rd_data,
        input  fill_way_index, tag_write, fill_busy, fill_done, mem_req_valid,
               mem_req_addr, data_we, data_addr, data_wdata, critical_valid
    );

endinterface

// File: rtl/cache_fill_beat_ctr.sv
// Wrapping beat counter: loads the burst start beat, advances per accepted
// beat, and flags the beat that completes the line.
module cache_fill_beat_ctr #(
    parameter int W = 3
) (
    input  logic         main_clk,
    input  logic         main_rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] beat,
    output logic         last
);

    logic [W-1:0] beat_reg;
    logic [W-1:0] start_reg;

    always_ff @(posedge main_clk or posedge main_rst) begin
        if (main_rst) begin
            beat_reg  <= '0;
            start_reg <= '0;
        end else if (load) begin
            beat_reg  <= load_val;
            start_reg <= load_val;
        end else if (en) begin
            beat_reg  <= beat_reg + W'(1);
        end
    end

    assign beat = beat_reg;
    // The line is complete when the next beat would wrap back to the start.
    assign last = ((beat_reg + W'(1)) == start_reg);

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache miss fill controller: picks a victim way, fetches the 8-beat line,
// writes the data RAM, then strobes the tag write.
// Build option: CACHE_FILL_CRITICAL_WORD_FIRST_EN starts the burst at the faulting beat.
import cache_pkg::*;

module cache_fill_ctrl #(
    parameter int BEATS  = CACHE_LINE_BEATS,
    parameter int ADDR_W = CACHE_ADDR_W
) (
    input  logic              main_clk,
    input  logic              main_rst,
    cache_fill_ctrl_if.master bus
);

    localparam int BEAT_W = $clog2(BEATS);

    fill_state_t            state_reg, state_next;
    logic [CACHE_WAY_W-1:0] victim_ctr_reg;
    logic [CACHE_WAY_W-1:0] way_reg;
    logic                   all_beats_reg;
    logic                   data_we_reg;
    logic                   critical_reg;
    logic [15:0]            data_addr_reg;
    logic [15:0]            data_wdata_reg;
    logic [BEAT_W-1:0]      start_beat;
    logic [BEAT_W-1:0]      beat;
    logic                   last_beat;
    logic                   accept_fault;
    logic                   beat_accept;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^{bus.target_address[30:ADDR_W], bus.target_address[0]};

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    assign start_beat = bus.target_address[BEAT_W:1];
`else
    assign start_beat = '0;
`endif

    assign accept_fault = (state_reg == IDLE) && bus.hard_fault;
    // Once all beats are in, FILL lingers one cycle for the last data write.
    assign beat_accept  = (state_reg == FILL) && bus.mem_rd_valid && !all_beats_reg;

    cache_fill_beat_ctr #(
        .W(BEAT_W)
    ) u_beat_ctr (
        .main_clk (main_clk),
        .main_rst (main_rst),
        .load     (accept_fault),
        .load_val (start_beat),
        .en       (beat_accept),
        .beat     (beat),
        .last     (last_beat)
    );

    always_comb begin
        state_next        = state_reg;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_addr  = '0;
        bus.tag_write     = 1'b0;
        bus.fill_done     = 1'b0;
        bus.fill_busy     = (state_reg != IDLE);
        case (state_reg)
            IDLE: if (bus.hard_fault) state_next = REQ;
            REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = {bus.target_address[ADDR_W-1:BEAT_W+1], beat};
                if (bus.mem_req_ready) state_next = FILL;
            end
            FILL: if (all_beats_reg) state_next = TAG;
            TAG: begin
                bus.tag_write = 1'b1;
                state_next    = DONE;
            end
            DONE: begin
                bus.fill_done = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge main_clk or posedge main_rst) begin
        if (main_rst) begin
            state_reg      <= IDLE;
            victim_ctr_reg <= '0;
            way_reg        <= '0;
            all_beats_reg  <= 1'b0;
            data_we_reg    <= 1'b0;
            critical_reg   <= 1'b0;
            data_addr_reg  <= '0;
            data_wdata_reg <= '0;
        end else begin
            state_reg   <= state_next;
            data_we_reg <= beat_accept;
            critical_reg <= beat_accept && (beat == bus.target_address[BEAT_W:1]);
            if (accept_fault) begin
                way_reg       <= victim_ctr_reg;
                all_beats_reg <= 1'b0;
            end else if (beat_accept && last_beat) begin
                all_beats_reg <= 1'b1;
            end
            if (state_reg == DONE) begin
                victim_ctr_reg <= victim_ctr_reg + CACHE_WAY_W'(1);
            end
            if (beat_accept) begin
                data_addr_reg  <= pack_data_addr(way_reg,
                                      bus.target_address[CACHE_INDEX_W+BEAT_W:BEAT_W+1], beat);
                data_wdata_reg <= bus.mem_rd_data;
            end
        end
    end

    assign bus.fill_way_index = way_reg;
    assign bus.data_we        = data_we_reg;
    assign bus.data_addr      = data_addr_reg;
    assign bus.data_wdata     = data_wdata_reg;
    assign bus.critical_valid = critical_reg;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: randomized fills checked against a line-level
// reference model (expected write list, victim sequence, cycle timing).
module tb_cache_fill_ctrl;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        main_clk = 1'b0;
    logic        main_rst = 1'b1;
    int          tests = 0;
    int          failed = 0;
    int          fill_count = 0;
    logic [15:0] salt = 16'h0;

    cache_fill_ctrl_if bus ();

    cache_fill_ctrl dut (
        .main_clk (main_clk),
        .main_rst (main_rst),
        .bus      (bus)
    );

    always #5 main_clk = ~main_clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [2:0] start_of(input logic [30:0] a);
        return CWF ? a[3:1] : 3'd0;
    endfunction

    // Memory contents: distinct per line and per beat, reshuffled each fill.
    function automatic logic [15:0] mem_word(input logic [21:0] line, input logic [2:0] b);
        return line[15:0] ^ {b, line[21:16], 7'd0} ^ salt;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_flags"}, 32'({bus.fill_busy, bus.fill_way_index, bus.tag_write, bus.fill_done,
                                    bus.mem_req_valid, bus.data_we, bus.critical_valid}), 0);
        check({tag, "_req_addr"}, 32'(bus.mem_req_addr), 0);
        check({tag, "_data_addr"}, 32'(bus.data_addr), 0);
        check({tag, "_data_wdata"}, 32'(bus.data_wdata), 0);
    endtask

    task automatic do_fill(input logic [30:0] addr, input int ready_wait, input int gap_pct,
                           input bit noise, input bit hold);
        logic [1:0]  way;
        logic [2:0]  s;
        logic [2:0]  crit;
        logic [2:0]  b;
        logic [24:0] exp_req;
        logic [24:0] req_addr;
        logic [15:0] exp_addr[$];
        logic [15:0] exp_data[$];
        logic [15:0] ea;
        logic [15:0] ed;
        int          cyc;
        int          sent;
        int          seen;
        int          tags;
        int          last_cyc;
        bit          done;
        bit          exp_crit;

        way     = 2'(fill_count % 4);
        s       = start_of(addr);
        crit    = addr[3:1];
        exp_req = {addr[25:4], s};
        salt    = 16'($urandom);
        for (int k = 0; k < 8; k++) begin
            b = 3'((int'(s) + k) % 8);
            exp_addr.push_back({way, addr[14:4], b});
            exp_data.push_back(mem_word(addr[25:4], b));
        end

        bus.target_address = addr;
        bus.hard_fault     = 1'b1;
        @(posedge main_clk); #1;
        bus.hard_fault = 1'b0;
        cyc = 1;
        check("accept_busy", 32'(bus.fill_busy), 1);
        check("victim_way", 32'(bus.fill_way_index), 32'(way));

        for (int i = 0; i < ready_wait; i++) begin
            bus.mem_req_ready = 1'b0;
            check("req_valid_stall", 32'(bus.mem_req_valid), 1);
            check("req_addr_stall", 32'(bus.mem_req_addr), 32'(exp_req));
            if (noise) bus.hard_fault = ($urandom_range(0, 1) == 1);
            @(posedge main_clk); #1;
            cyc++;
        end
        check("req_valid", 32'(bus.mem_req_valid), 1);
        check("req_addr", 32'(bus.mem_req_addr), 32'(exp_req));
        req_addr          = bus.mem_req_addr;
        bus.mem_req_ready = 1'b1;
        @(posedge main_clk); #1;
        cyc++;
        bus.mem_req_ready = 1'b0;

        sent = 0; seen = 0; tags = 0; last_cyc = 0; done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            bus.mem_rd_valid = 1'b0;
            if (sent < 8 && int'($urandom_range(0, 99)) >= gap_pct) begin
                bus.mem_rd_valid = 1'b1;
                bus.mem_rd_data  = mem_word(req_addr[24:3], 3'(int'(req_addr[2:0]) + sent));
                sent++;
                if (sent == 8) last_cyc = cyc;
            end
            if (noise) bus.hard_fault = ($urandom_range(0, 3) == 0);
            @(posedge main_clk); #1;
            cyc++;
            bus.mem_rd_valid = 1'b0;
            check("busy_hold", 32'(bus.fill_busy), 1);
            check("way_hold", 32'(bus.fill_way_index), 32'(way));
            check("no_req_in_fill", 32'(bus.mem_req_valid), 0);
            exp_crit = 1'b0;
            if (bus.data_we) begin
                seen++;
                check("write_count", 32'(seen <= 8), 1);
                if (exp_addr.size() > 0) begin
                    ea = exp_addr.pop_front();
                    ed = exp_data.pop_front();
                    exp_crit = (ea[2:0] == crit);
                    check("write_addr", 32'(bus.data_addr), 32'(ea));
                    check("write_data", 32'(bus.data_wdata), 32'(ed));
                end
            end
            check("critical_valid", 32'(bus.critical_valid), 32'(exp_crit));
            if (bus.tag_write) begin
                tags++;
                check("tag_after_8_writes", seen, 8);
                check("tag_cycle", cyc, last_cyc + 2);
            end
            if (bus.fill_done) begin
                done = 1'b1;
                check("done_cycle", cyc, last_cyc + 3);
                check("tag_once", tags, 1);
            end
        end
        check("fill_completed", 32'(done), 1);

        // A fault held through DONE must wait for the following IDLE edge.
        bus.hard_fault = hold;
        @(posedge main_clk); #1;
        check("idle_after_done", 32'(bus.fill_busy), 0);
        fill_count++;
        $display("[TB] fill %0d addr=0x%07h way=%0d start=%0d writes=%0d done_cycle=%0d",
                 fill_count, addr, way, s, seen, cyc);
    endtask

    initial begin
        bus.hard_fault     = 1'b0;
        bus.target_address = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_rd_valid   = 1'b0;
        bus.mem_rd_data    = '0;

        repeat (2) @(posedge main_clk);
        #1;
        check_outputs_zero("reset");
        main_rst = 1'b0;

        // Stray read beats while idle.
        for (int i = 0; i < 3; i++) begin
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = 16'($urandom);
            @(posedge main_clk); #1;
            check("idle_no_write", 32'(bus.data_we), 0);
            check("idle_no_req", 32'(bus.mem_req_valid), 0);
            check("idle_not_busy", 32'(bus.fill_busy), 0);
        end
        bus.mem_rd_valid = 1'b0;
        @(posedge main_clk); #1;
        check("idle_no_late_write", 32'(bus.data_we), 0);

        do_fill(31'h0123456, 0, 0, 1'b0, 1'b0);
        do_fill(31'($urandom), 4, 40, 1'b0, 1'b0);
        do_fill(31'($urandom), 2, 30, 1'b1, 1'b0);
        do_fill(31'($urandom), 1, 20, 1'b0, 1'b1);
        do_fill(31'($urandom), 0, 25, 1'b0, 1'b0);
        do_fill({27'($urandom), 4'hA}, 0, 0, 1'b0, 1'b0);

        // Abort a fill after three beats.
        bus.target_address = 31'h1A5F0C2;
        bus.hard_fault     = 1'b1;
        @(posedge main_clk); #1;
        bus.hard_fault = 1'b0;
        check("midfill_way", 32'(bus.fill_way_index), 32'(fill_count % 4));
        bus.mem_req_ready = 1'b1;
        @(posedge main_clk); #1;
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = 16'($urandom);
            @(posedge main_clk); #1;
        end
        bus.mem_rd_valid = 1'b0;
        check("midfill_writing", 32'(bus.data_we), 1);
        main_rst = 1'b1;
        #1;
        check_outputs_zero("reset_mid_fill");
        repeat (2) begin
            @(posedge main_clk); #1;
            check("reset_no_tag", 32'(bus.tag_write), 0);
        end
        main_rst   = 1'b0;
        fill_count = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge main_clk); #1;
            check("abort_no_tag", 32'(bus.tag_write), 0);
            check("abort_idle", 32'(bus.fill_busy), 0);
        end
        do_fill(31'($urandom), 1, 20, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
